// File: rtl/ext_ctrl_debounce.sv
// ext_ctrl_debounce: synchronises, optionally inverts and debounces external
// control pins, then feeds clean active-high levels to the PIO in_port.
// A small Avalon-MM slave exposes the threshold, channel enables and a
// saturating glitch counter.
module ext_ctrl_debounce #(
    parameter int WIDTH          = 4,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_THRESH = 50000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] ctrl_out,
    output logic [WIDTH-1:0] ctrl_rise
);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_THRESH = 2'd1;
    localparam logic [1:0] ADDR_EN     = 2'd2;
    localparam logic [1:0] ADDR_GCNT   = 2'd3;

    // Conditioned pin level: active-high regardless of board polarity.
    logic [WIDTH-1:0] s;
    assign s = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [15:0]      gcnt_q, gcnt_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [CNT_W-1:0] eff_thresh;
    logic [CNT_W-1:0] thresh_m1;
    logic [WIDTH-1:0] glitch;
    logic             wr;

    // Upper write-data bits beyond the register widths carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Next-state logic: per-channel debounce, register writes, read mux.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a variable unassigned and infers a latch.
        ctrl_d   = ctrl_q;
        glitch   = '0;
        thresh_d = thresh_q;
        en_d     = en_q;
        gcnt_d   = gcnt_q;
        rdata_d  = '0;

        wr         = chipselect && !write_n;
        eff_thresh = (thresh_q == '0) ? CNT_W'(1) : thresh_q;
        thresh_m1  = eff_thresh - CNT_W'(1);

        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (en_q[i]) begin
                if (sync2_q[i] != ctrl_q[i]) begin
                    // >= keeps a mid-count threshold decrease from overrunning.
                    if (cnt_q[i] >= thresh_m1) begin
                        ctrl_d[i] = ~ctrl_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    glitch[i] = (cnt_q[i] != '0);
                end
            end
        end

        rise_d = ctrl_d & ~ctrl_q;

        if (wr && address == ADDR_THRESH) thresh_d = writedata[CNT_W-1:0];
        if (wr && address == ADDR_EN)     en_d     = writedata[WIDTH-1:0];

        // A clear write takes priority over a simultaneous glitch.
        if (wr && address == ADDR_GCNT) begin
            gcnt_d = '0;
        end else if ((|glitch) && gcnt_q != 16'hFFFF) begin
            gcnt_d = gcnt_q + 16'd1;
        end

        case (address)
            ADDR_STATUS: begin
                rdata_d[WIDTH-1:0]   = ctrl_q;
                rdata_d[WIDTH+7:8]   = sync2_q;
            end
            ADDR_THRESH: rdata_d[CNT_W-1:0] = thresh_q;
            ADDR_EN:     rdata_d[WIDTH-1:0] = en_q;
            default:     rdata_d[15:0]      = gcnt_q;
        endcase
    end

    // State registers: synchroniser, debounce state, CSRs and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            ctrl_q   <= '0;
            rise_q   <= '0;
            thresh_q <= CNT_W'(DEFAULT_THRESH);
            en_q     <= '1;
            gcnt_q   <= '0;
            rdata_q  <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is reset explicitly like any other state.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge; sync2 must see the old sync1.
            sync1_q  <= s;
            sync2_q  <= sync1_q;
            ctrl_q   <= ctrl_d;
            rise_q   <= rise_d;
            thresh_q <= thresh_d;
            en_q     <= en_d;
            gcnt_q   <= gcnt_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign ctrl_out  = ctrl_q;
    assign ctrl_rise = rise_q;
    assign readdata  = rdata_q;

endmodule

// File: tb/tb_ext_ctrl_debounce.sv
// Directed testbench for ext_ctrl_debounce (WIDTH=4, CNT_W=16, ACTIVE_LOW=1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ext_ctrl_debounce;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  raw_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  ctrl_out;
    logic [3:0]  ctrl_rise;

    int n_checks = 0;
    int n_errors = 0;

    ext_ctrl_debounce #(
        .WIDTH(4), .CNT_W(16), .DEFAULT_THRESH(50000), .ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .ctrl_out   (ctrl_out),
        .ctrl_rise  (ctrl_rise)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending on the following falling edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        step();
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        raw_in     = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Power-on reset
        @(negedge clk);
        check("rst_ctrl_out", 32'(ctrl_out), 32'h0);
        check("rst_ctrl_rise", 32'(ctrl_rise), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read("rst_thresh", 2'd1, 32'd50000);
        reg_read("rst_en", 2'd2, 32'h0000_000F);
        reg_read("rst_gcnt", 2'd3, 32'h0);
        reg_read("rst_status", 2'd0, 32'h0);

        // Clean press on channel 0, thresh = 4: toggle at E5
        reg_write(2'd1, 32'd4);
        raw_in = 4'hE;
        step(5);
        check("press_before_e5", 32'(ctrl_out), 32'h0);
        step();
        check("press_out_e5", 32'(ctrl_out), 32'h1);
        check("press_rise_e5", 32'(ctrl_rise), 32'h1);
        step();
        check("press_rise_e6", 32'(ctrl_rise), 32'h0);
        check("press_out_e6", 32'(ctrl_out), 32'h1);
        reg_read("press_status", 2'd0, 32'h0000_0101);
        reg_read("press_gcnt", 2'd3, 32'h0);
        raw_in = 4'hF;
        step(7);
        check("release_out", 32'(ctrl_out), 32'h0);
        check("release_rise", 32'(ctrl_rise), 32'h0);

        // Bounce on channel 1: active for 2 cycles only
        raw_in = 4'hD;
        step(2);
        raw_in = 4'hF;
        step(6);
        check("bounce_out", 32'(ctrl_out), 32'h0);
        reg_read("bounce_gcnt", 2'd3, 32'h1);

        // Bypass: thresh = 0 behaves as 1, toggle at E2
        reg_write(2'd1, 32'd0);
        raw_in = 4'hB;
        step(2);
        check("bypass_e1", 32'(ctrl_out), 32'h0);
        step();
        check("bypass_e2_out", 32'(ctrl_out), 32'h4);
        check("bypass_e2_rise", 32'(ctrl_rise), 32'h4);
        raw_in = 4'hF;
        step(3);
        check("bypass_release", 32'(ctrl_out), 32'h0);
        raw_in = 4'h7;
        step();
        raw_in = 4'hF;
        step();
        check("pulse_e1", 32'(ctrl_out), 32'h0);
        step();
        check("pulse_e2_out", 32'(ctrl_out), 32'h8);
        check("pulse_e2_rise", 32'(ctrl_rise), 32'h8);
        step();
        check("pulse_e3_out", 32'(ctrl_out), 32'h0);
        reg_read("bypass_gcnt", 2'd3, 32'h1);

        // Mask channel 0: frozen output, synchroniser still visible
        reg_write(2'd1, 32'd4);
        reg_write(2'd2, 32'hE);
        raw_in = 4'hE;
        step(8);
        check("mask_out", 32'(ctrl_out), 32'h0);
        reg_read("mask_status", 2'd0, 32'h0000_0100);
        raw_in = 4'hF;
        step(4);
        reg_read("mask_gcnt", 2'd3, 32'h1);

        // Clear write in the same cycle as a channel-2 glitch (edge E4)
        raw_in = 4'hB;
        step(2);
        raw_in = 4'hF;
        step(2);
        reg_write(2'd3, 32'h0);
        reg_read("clear_race_gcnt", 2'd3, 32'h0);

        // Threshold shrink: cnt = 10 under thresh 20, write 5 -> toggle next edge
        reg_write(2'd2, 32'hF);
        reg_write(2'd1, 32'd20);
        raw_in = 4'hD;
        step(12);
        reg_write(2'd1, 32'd5);
        check("shrink_write_edge", 32'(ctrl_out), 32'h0);
        step();
        check("shrink_next_out", 32'(ctrl_out), 32'h2);
        check("shrink_next_rise", 32'(ctrl_rise), 32'h2);
        raw_in = 4'hF;
        step(8);
        check("shrink_release", 32'(ctrl_out), 32'h0);

        // Reset asserted mid-activity, then re-qualification from zero
        raw_in = 4'hE;
        step(7);
        check("pre_reset_out", 32'(ctrl_out), 32'h1);
        reg_read("pre_reset_en", 2'd2, 32'h0000_000F);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ctrl_out", 32'(ctrl_out), 32'h0);
        check("midrst_ctrl_rise", 32'(ctrl_rise), 32'h0);
        check("midrst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read("midrst_thresh", 2'd1, 32'd50000);
        reg_read("midrst_en", 2'd2, 32'h0000_000F);
        reg_write(2'd1, 32'd4);
        step(2);
        check("requal_e4", 32'(ctrl_out), 32'h0);
        step();
        check("requal_e5_out", 32'(ctrl_out), 32'h1);
        check("requal_e5_rise", 32'(ctrl_rise), 32'h1);
        reg_read("midrst_gcnt", 2'd3, 32'h0);

        // Saturation: channels 0 and 1 glitch on alternate cycles
        raw_in = 4'hF;
        step(8);
        check("sat_pre_out", 32'(ctrl_out), 32'h0);
        reg_write(2'd1, 32'd2);
        for (int k = 0; k < 33000; k++) begin
            raw_in = 4'hE;
            step();
            raw_in = 4'hD;
            step();
        end
        raw_in = 4'hF;
        step(4);
        check("sat_out", 32'(ctrl_out), 32'h0);
        reg_read("sat_gcnt", 2'd3, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
